ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1, meaning RAM cycles from ram_rd sampled high to ram_rdata valid (legal 1..4).
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports m0_req / m1_req  input  1  requester N requests a RAM access.
REQ-005 SHALL have ports m0_wr / m1_wr  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports m0_addr / m1_addr  input  4  RAM address.
REQ-007 SHALL have ports m0_wdata / m1_wdata  input  8  write data.
REQ-008 SHALL have ports m0_gnt / m1_gnt  output  1  one-cycle pulse: command accepted.
REQ-009 SHALL have ports m0_done / m1_done  output  1  one-cycle pulse: access complete.
REQ-010 SHALL have ports m0_rdata / m1_rdata  output  8  read result, valid from done and held until the next read by that port.
REQ-011 SHALL have ports ram_rd, ram_wr  output  1  RAM strobes, never both high.
REQ-012 SHALL have ports ram_addr  output  4 and ram_wdata  output  8  RAM command.
REQ-013 SHALL have port ram_rdata  input  8  RAM read data.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> (write: DONE | read: WAIT) -> DONE -> IDLE; all outputs registered.
REQ-015 SHALL sample req only in IDLE; a req dropped before being sampled causes no access.
REQ-016 SHALL, on one req in IDLE at cycle T, enter ISSUE at T+1 with that port's gnt=1, latched addr/wdata on ram_addr/ram_wdata, and ram_wr or ram_rd high for exactly that cycle.
REQ-017 SHALL, on both reqs in IDLE, grant the port not granted most recently (last_gnt); last_gnt updates on every grant.
REQ-018 SHALL latch wr/addr/wdata at grant; later changes to requester inputs do not affect the access in flight.
REQ-019 SHALL, for writes, go ISSUE -> DONE; done is high at T+2; write latency is 2 cycles.
REQ-020 SHALL, for reads, hold WAIT for RD_LATENCY cycles via a down-counter, capture ram_rdata into mN_rdata on the WAIT->DONE edge, and assert done at T+2+RD_LATENCY.
REQ-021 SHALL return DONE -> IDLE unconditionally; a still-asserted req is re-sampled in IDLE as a new request; minimum spacing between grants is 3 cycles for writes.
REQ-022 SHALL never assert gnt or done to both ports in the same cycle, and SHALL not change the other port's rdata.
REQ-023 SHALL drive ram_addr/ram_wdata with the last issued values outside ISSUE, with ram_rd=ram_wr=0.

Reset
REQ-024 SHALL, on rst at any state including mid-access, go to IDLE at the next edge with gnt, done, ram_rd and ram_wr = 0, ram_addr = 0, ram_wdata = 0, m0_rdata = m1_rdata = 0, and last_gnt = 1, so m0 wins the first tie.
REQ-025 SHALL issue no done for an access aborted by reset.

Structure
REQ-026 SHALL take ADDR_W=4, DATA_W=8 and the FSM state enum from shared package cpu_pkg.
REQ-027 SHALL place the two-way round-robin picker in sub-module rr_arb2 (inputs req[1:0], last; output grant index and valid).

Verification
REQ-028 Write: m0 req, wr=1, addr=0x3, wdata=0xA5 at T -> m0_gnt, ram_wr, ram_addr=3, ram_wdata=A5 at T+1; m0_done at T+2.
REQ-029 Read with RD_LATENCY=1: RAM model returns 0x5A for addr 0x3; m1 read of addr 3 at T -> ram_rd at T+1, m1_done at T+3 with m1_rdata=0x5A; m0_rdata unchanged.
REQ-030 Tie: both req held continuously after reset -> grants alternate m0, m1, m0, m1; no gnt overlap.
REQ-031 Reset mid-read: assert rst during WAIT with RD_LATENCY=3 -> next edge all outputs 0; no done pulse; next simultaneous req grants m0.
REQ-032 Input change after grant: m0 changes addr from 0x3 to 0x7 one cycle after gnt -> access completes at 0x3; next access uses 0x7.
REQ-033 Dropped request: m1_req pulses for one cycle while the FSM is in WAIT -> no m1 gnt and no RAM strobe for m1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths and FSM state encoding for the two-port RAM arbiter.
package cpu_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// Requester handshakes and RAM command bus of the two-port arbiter.
interface ram_arbiter_if;
  import cpu_pkg::*;

  logic              m0_req,   m1_req;
  logic              m0_wr,    m1_wr;
  logic [ADDR_W-1:0] m0_addr,  m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt,   m1_gnt;
  logic              m0_done,  m1_done;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              ram_rd,   ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata, ram_rdata,
    output m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata,
           ram_rd, ram_wr, ram_addr, ram_wdata
  );

  modport master (
    output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata, ram_rdata,
    input  m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata,
           ram_rd, ram_wr, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the port not granted last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  // Select the winning port index from the pending requests
  always_comb begin
    grant = 1'b0;
    valid = 1'b0;
    case (req)
      2'b01: begin
        grant = 1'b0;
        valid = 1'b1;
      end
      2'b10: begin
        grant = 1'b1;
        valid = 1'b1;
      end
      2'b11: begin
        grant = ~last;
        valid = 1'b1;
      end
      default: begin
        grant = 1'b0;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester single-port RAM arbiter: one access in flight, round-robin on ties,
// registered strobes and per-port completion pulses.
module ram_arbiter
  import cpu_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input logic           clk,
  input logic           rst,
  ram_arbiter_if.slave  bus
);

  localparam logic [2:0] RD_LAT_C = 3'(RD_LATENCY);

  state_t            state_r;
  logic              last_gnt_r;
  logic              port_r;
  logic              wr_r;
  logic [2:0]        cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata0_r, rdata1_r;
  logic              gnt0_r, gnt1_r, done0_r, done1_r;
  logic              ram_rd_r, ram_wr_r;

  logic              pick_s, pick_valid_s;
  logic              sel_wr_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  rr_arb2 u_rr_arb2 (
    .req   ({bus.m1_req, bus.m0_req}),
    .last  (last_gnt_r),
    .grant (pick_s),
    .valid (pick_valid_s)
  );

  // Route the winning requester's command toward the grant registers
  always_comb begin
    sel_wr_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    if (pick_s) begin
      sel_wr_s    = bus.m1_wr;
      sel_addr_s  = bus.m1_addr;
      sel_wdata_s = bus.m1_wdata;
    end else begin
      sel_wr_s    = bus.m0_wr;
      sel_addr_s  = bus.m0_addr;
      sel_wdata_s = bus.m0_wdata;
    end
  end

  // Access sequencer; gnt/done/strobes default low so each is a single-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      last_gnt_r <= 1'b1;
      port_r     <= 1'b0;
      wr_r       <= 1'b0;
      cnt_r      <= 3'd0;
      addr_r     <= '0;
      wdata_r    <= '0;
      rdata0_r   <= '0;
      rdata1_r   <= '0;
      gnt0_r     <= 1'b0;
      gnt1_r     <= 1'b0;
      done0_r    <= 1'b0;
      done1_r    <= 1'b0;
      ram_rd_r   <= 1'b0;
      ram_wr_r   <= 1'b0;
    end else begin
      gnt0_r   <= 1'b0;
      gnt1_r   <= 1'b0;
      done0_r  <= 1'b0;
      done1_r  <= 1'b0;
      ram_rd_r <= 1'b0;
      ram_wr_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            state_r    <= ST_ISSUE;
            port_r     <= pick_s;
            last_gnt_r <= pick_s;
            wr_r       <= sel_wr_s;
            addr_r     <= sel_addr_s;
            wdata_r    <= sel_wdata_s;
            gnt0_r     <= ~pick_s;
            gnt1_r     <= pick_s;
            ram_wr_r   <= sel_wr_s;
            ram_rd_r   <= ~sel_wr_s;
          end
        end
        ST_ISSUE: begin
          if (wr_r) begin
            state_r <= ST_DONE;
            done0_r <= ~port_r;
            done1_r <= port_r;
          end else begin
            state_r <= ST_WAIT;
            cnt_r   <= RD_LAT_C;
          end
        end
        ST_WAIT: begin
          // RAM data is valid in the last counted wait cycle
          if (cnt_r <= 3'd1) begin
            state_r <= ST_DONE;
            done0_r <= ~port_r;
            done1_r <= port_r;
            if (port_r) begin
              rdata1_r <= bus.ram_rdata;
            end else begin
              rdata0_r <= bus.ram_rdata;
            end
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.m0_gnt    = gnt0_r;
  assign bus.m1_gnt    = gnt1_r;
  assign bus.m0_done   = done0_r;
  assign bus.m1_done   = done1_r;
  assign bus.m0_rdata  = rdata0_r;
  assign bus.m1_rdata  = rdata1_r;
  assign bus.ram_rd    = ram_rd_r;
  assign bus.ram_wr    = ram_wr_r;
  assign bus.ram_addr  = addr_r;
  assign bus.ram_wdata = wdata_r;

endmodule
